// File: rtl/switch_pio_edge_irq.sv
// Memory-mapped switch/pushbutton input port: synchroniser, per-bit debounce,
// edge capture with write-1-to-clear, and a maskable level interrupt.
module switch_pio_edge_irq #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RAW  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_prev;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             unused_wdata;

  // Bus: single-cycle slave, no wait states. A write commits on the clk edge
  // where chipselect=1 and write_n=0. readdata is refreshed from address on
  // every edge regardless of chipselect, so read data lags address by one cycle.
  assign wr_en        = chipselect & ~write_n;
  assign unused_wdata = ^{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign raw = sync_q[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES > 0) begin : g_debounce
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0][CW-1:0] cnt;
    logic [WIDTH-1:0]         db_q;

    // Counter only runs while raw disagrees with the accepted level; any
    // agreement (a glitch ending) returns it to zero.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt  <= '0;
        db_q <= '0;
      end else begin
        for (int b = 0; b < WIDTH; b++) begin
          if (raw[b] == db_q[b]) begin
            cnt[b] <= '0;
          end else if (cnt[b] == CNT_LAST) begin
            db_q[b] <= raw[b];
            cnt[b]  <= '0;
          end else begin
            cnt[b] <= cnt[b] + CW'(1);
          end
        end
      end
    end

    assign db = db_q;
  end else begin : g_bypass
    assign db = raw;
  end

  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      0:       edge_hit = db & ~db_prev;
      1:       edge_hit = ~db & db_prev;
      default: edge_hit = db ^ db_prev;
    endcase
  end

  assign edge_clr = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

  // A new edge in the same cycle as its clear wins: the OR comes last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_prev      <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
    end else begin
      db_prev      <= db;
      edge_capture <= (edge_capture & ~edge_clr) | edge_hit;
      if (wr_en && address == ADDR_MASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA: rd_next = 32'(db);
      ADDR_RAW:  rd_next = 32'(raw);
      ADDR_MASK: rd_next = 32'(irq_mask);
      ADDR_EDGE: rd_next = 32'(edge_capture);
      default:   rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_switch_pio_edge_irq.sv
// Randomised and directed bench for switch_pio_edge_irq: a rising-edge and an
// any-edge instance share all inputs and are compared against one reference model.
module tb_switch_pio_edge_irq;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DC = 4;

  logic         clk;
  logic         reset_n;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [W-1:0] in_port;
  logic [31:0]  readdata;
  logic         irq;
  logic [31:0]  readdata_any;
  logic         irq_any;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  switch_pio_edge_irq #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(0)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  switch_pio_edge_irq #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2)) u_dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_any),
    .in_port(in_port), .irq(irq_any)
  );

  // ---------------- reference model ----------------
  // Input seen through a pure delay line; a level is accepted once the last
  // DC samples all disagree with the current accepted level.
  logic [W-1:0] in_q[$];
  logic [W-1:0] s_hist[$];
  logic [W-1:0] m_s, m_db, m_prev, m_mask, m_cap0, m_cap1;
  logic [31:0]  m_rd0, m_rd1;
  logic [W-1:0] t_clr, t_db;
  bit           t_all;
  logic         m_irq0, m_irq1;

  assign m_irq0 = |(m_cap0 & m_mask);
  assign m_irq1 = |(m_cap1 & m_mask);

  function automatic logic [31:0] rd_of(input logic [1:0] a, input logic [W-1:0] cap);
    case (a)
      2'd0:    return 32'(m_db);
      2'd1:    return 32'(m_s);
      2'd2:    return 32'(m_mask);
      default: return 32'(cap);
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q.delete();
      for (int i = 0; i < SS; i++) in_q.push_back('0);
      s_hist.delete();
      m_s = '0; m_db = '0; m_prev = '0; m_mask = '0;
      m_cap0 = '0; m_cap1 = '0; m_rd0 = '0; m_rd1 = '0;
    end else begin
      m_rd0 = rd_of(address, m_cap0);
      m_rd1 = rd_of(address, m_cap1);
      t_clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      m_cap0 = (m_cap0 & ~t_clr) | (m_db & ~m_prev);
      m_cap1 = (m_cap1 & ~t_clr) | (m_db ^ m_prev);
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      s_hist.push_back(m_s);
      if (s_hist.size() > DC) void'(s_hist.pop_front());
      t_db = m_db;
      if (s_hist.size() == DC) begin
        for (int b = 0; b < W; b++) begin
          t_all = 1;
          foreach (s_hist[j]) if (s_hist[j][b] == m_db[b]) t_all = 0;
          if (t_all) t_db[b] = m_s[b];
        end
      end
      m_prev = m_db;
      m_db   = t_db;
      in_q.push_back(in_port);
      void'(in_q.pop_front());
      m_s = in_q[0];
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_rd", readdata, m_rd0);
      check("model_irq", 32'(irq), 32'(m_irq0));
      check("model_rd_any", readdata_any, m_rd1);
      check("model_irq_any", 32'(irq_any), 32'(m_irq1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    tick(1);
    chipselect = 0; write_n = 1;
  endtask

  task automatic expect_read(input string tag, input logic [1:0] a, input bit any_inst,
                             input logic [31:0] exp);
    exp_q.push_back(exp);
    address = a;
    tick(1);
    check(tag, any_inst ? readdata_any : readdata, exp_q.pop_front());
  endtask

  // Edges until the held address reads back value under mask; -1 on timeout.
  task automatic wait_read(input logic [1:0] a, input logic [31:0] msk,
                           input logic [31:0] val, output int n);
    address = a;
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if ((readdata & msk) == val) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int  lat;
  bit  seen;

  initial begin
    reset_n = 1; address = 0; chipselect = 0; write_n = 1; writedata = 0; in_port = 4'hF;
    #1 reset_n = 0;
    #1 chk_on = 1;

    // 1: reset with inputs high
    tick(3);
    check("reset_rd", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    reset_n = 1;
    wait_read(2'd0, 32'hF, 32'hF, lat);
    check("data_latency", 32'(lat), 32'(SS + DC + 1));
    expect_read("cap_after_reset", 2'd3, 0, 32'hF);
    expect_read("raw_after_reset", 2'd1, 0, 32'hF);

    // 2: clean rising edge; read shows capture one edge after it sets
    in_port = 4'h0;
    tick(10);
    bus_write(2'd3, 32'hF);
    in_port = 4'h5;
    wait_read(2'd3, 32'hF, 32'h5, lat);
    check("cap_latency", 32'(lat), 32'(SS + DC + 2));
    expect_read("cap_clean", 2'd3, 0, 32'h5);
    expect_read("data_clean", 2'd0, 0, 32'h5);

    // 3: three-cycle glitch on bit 1
    address = 2'd1;
    seen = 0;
    in_port = 4'h7;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) in_port = 4'h5;
      tick(1);
      if (readdata[1]) seen = 1;
    end
    check("raw_pulse_seen", 32'(seen), 32'h1);
    expect_read("data_glitch", 2'd0, 0, 32'h5);
    expect_read("cap_glitch", 2'd3, 0, 32'h5);
    in_port = 4'h7;
    wait_read(2'd3, 32'h2, 32'h2, lat);
    check("cnt_restart_latency", 32'(lat), 32'(SS + DC + 2));
    in_port = 4'h5;
    tick(10);
    bus_write(2'd3, 32'h2);

    // 4: interrupt masking and clearing
    check("irq_mask0", 32'(irq), 32'h0);
    bus_write(2'd2, 32'h1);
    check("irq_mask1", 32'(irq), 32'h1);
    bus_write(2'd3, 32'h1);
    check("irq_cleared", 32'(irq), 32'h0);
    expect_read("cap_after_clr", 2'd3, 0, 32'h4);
    bus_write(2'd2, 32'hFFFF_FFFF);
    expect_read("mask_readback", 2'd2, 0, 32'hF);
    check("irq_mask_all", 32'(irq), 32'h1);

    // 5: bit 3 edge lands on the edge of its own clear
    in_port = 4'hD;
    tick(SS + DC);
    bus_write(2'd3, 32'h8);
    expect_read("set_wins", 2'd3, 0, 32'hC);
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'h0);
    expect_read("data_ro", 2'd0, 0, 32'hD);
    expect_read("raw_ro", 2'd1, 0, 32'hD);
    expect_read("mask_kept", 2'd2, 0, 32'hF);

    // 6: reset two cycles into debounce
    in_port = 4'h2;
    tick(SS + 2);
    reset_n = 0;
    tick(2);
    check("midreset_rd", readdata, 32'h0);
    check("midreset_irq", 32'(irq_any), 32'h0);
    reset_n = 1;
    check("release_rd", readdata, 32'h0);
    wait_read(2'd0, 32'hF, 32'h2, lat);
    check("fresh_latency", 32'(lat), 32'(SS + DC + 1));
    expect_read("mask_after_reset", 2'd2, 0, 32'h0);
    expect_read("cap_after_midreset", 2'd3, 0, 32'h2);

    // any-edge instance records a falling bit 0
    in_port = 4'h3;
    tick(10);
    bus_write(2'd3, 32'hF);
    in_port = 4'h2;
    tick(10);
    expect_read("any_fall", 2'd3, 1, 32'h1);
    expect_read("rise_no_fall", 2'd3, 0, 32'h0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom_range(0, 15));
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      writedata  = $urandom;
      tick(1);
    end
    chipselect = 0;
    write_n = 1;
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_pio_edge_irq.md
Name: switch_pio_edge_irq

Overview:
- Parametrised memory-mapped input port for board switches and pushbuttons.
- Adds four functions to a plain input-read port: input synchronisation, per-bit debounce, edge capture with write-1-to-clear, and a maskable level interrupt.
- Sits on the system interconnect as a 4-word slave with registered readdata. The irq line goes to the processor interrupt controller.

Parameters:
- WIDTH, 4: number of input bits, 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit, 2..4.
- DEBOUNCE_CYCLES, 0: consecutive stable clk cycles required to accept a new level. 0 = debounce bypassed.
- EDGE_TYPE, 0: edge recorded in capture register. 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_port  in  WIDTH  asynchronous switch inputs
- irq  out  1  level interrupt, active high

Behaviour:
- Reset (asynchronous assert; deassert takes effect at clk edge) clears everything to 0: sync chain, debounce counters, debounced value db, db_prev, irq_mask, edge_capture, readdata. So irq = 0.
- Reset mid-debounce discards the count. The counter restarts from 0 after release.
- Synchroniser: s = in_port delayed by SYNC_STAGES flops.
- Debounce (DEBOUNCE_CYCLES > 0), per bit, independent counter of width clog2(DEBOUNCE_CYCLES)+1:
  - s == db: cnt <= 0.
  - s != db and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s != db and cnt == DEBOUNCE_CYCLES-1: db <= s, cnt <= 0.
  - Result: db follows s exactly DEBOUNCE_CYCLES cycles after s changes, provided s is held.
  - Any pulse on s shorter than DEBOUNCE_CYCLES cycles is rejected, and its counter returns to 0.
- Debounce (DEBOUNCE_CYCLES = 0): db = s, no extra delay.
- Edge detect:
  - db_prev <= db every cycle.
  - Rising: edge = db & ~db_prev. Falling: edge = ~db & db_prev. Any: edge = db ^ db_prev.
- Register map (32-bit words; bits above WIDTH read 0, writes to them ignored):
  - 0 DATA: db. Read-only; writes ignored.
  - 1 RAW: s, the synchronised but undebounced value. Read-only.
  - 2 IRQ_MASK: read/write, WIDTH bits.
  - 3 EDGE_CAPTURE: read; write-1-to-clear per bit.
- Write occurs when chipselect = 1 and write_n = 0, on that clk edge. There are no wait states.
- edge_capture update each cycle: edge_capture <= (edge_capture & ~clr) | edge.
  - clr = writedata[WIDTH-1:0] during a write to address 3, else 0.
  - Simultaneous clear and new edge on the same bit: the set wins and the bit stays 1.
- Read path:
  - readdata <= mux(address) on every clk edge, independent of chipselect.
  - Read latency is 1 cycle: data for the address presented in cycle N appears in cycle N+1.
  - Reads have no side effects; reading EDGE_CAPTURE does not clear it.
- irq = |(edge_capture & irq_mask). It is combinational from registers only, so it is glitch-free.
  - It asserts 1 cycle after db changes, if that bit is masked in.
  - It deasserts in the cycle after the clearing write, or after a mask write of 0.
- Input-to-capture latency: a held change on in_port sets the edge_capture bit SYNC_STAGES + DEBOUNCE_CYCLES + 1 clk edges after the first sampling edge.

Test Plan:
Bench configuration: WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=0 unless stated.
1. Reset with in_port = 4'hF held during reset.
   - Required during reset: readdata = 0, irq = 0.
   - Required after release: RAW reads 0xF after 2 cycles. DATA reads 0xF after 6 cycles.
   - Required after release: EDGE_CAPTURE reads 0xF, because db_prev was reset to 0.
2. Clean edge: write 0xF to EDGE_CAPTURE, then drive in_port 0→0x5 and hold.
   - Required: EDGE_CAPTURE bits 0 and 2 set exactly 7 edges after the change. EDGE_CAPTURE reads 0x00000005.
   - Required: DATA reads 0x00000005.
3. Glitch: drive bit 1 high for 3 cycles, then low.
   - Required: RAW shows the pulse.
   - Required: DATA and EDGE_CAPTURE are unchanged, and the bit 1 counter returns to 0.
4. Interrupt with capture = 0x5 and mask = 0.
   - Required: irq = 0.
   - Write 0x1 to IRQ_MASK: irq = 1 next cycle.
   - Write 0x1 to EDGE_CAPTURE: capture = 0x4, irq = 0 next cycle.
   - Write 0xFFFFFFFF to IRQ_MASK: reads back 0x0000000F, irq = 1.
5. Simultaneous event: a bit 3 rising edge arrives in the same cycle as a write of 0x8 to EDGE_CAPTURE.
   - Required: bit 3 remains 1.
   - Required: writes to addresses 0 and 1 change nothing.
6. Reset mid-debounce: assert reset_n low 2 cycles into a 4-cycle debounce.
   - Required: all registers read 0 after release. A fresh full 2+4 delay is needed before DATA reflects the input.
   - EDGE_TYPE=2 variant: a 0x1→0x0 transition sets capture bit 0.
